// File: rtl/muxn_pipe_if.sv
// muxn_pipe_if: channel and output handshake bundle for muxn_pipe.
// Revision: 1.0
`default_nettype none

interface muxn_pipe_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SELW = $clog2(N);

  logic [N*W-1:0]  d;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            sel_err;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output d, in_valid, sel, mode, out_ready,
    input  in_ready, sel_err, out_data, out_sel, out_valid
  );

  modport slave (
    input  d, in_valid, sel, mode, out_ready,
    output in_ready, sel_err, out_data, out_sel, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/muxn_pipe.sv
// muxn_pipe: N-channel registered mux, direct or round-robin select, valid/ready.
// Revision: 1.0
`default_nettype none

module muxn_pipe #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  muxn_pipe_if.slave    bus
);
  localparam int SELW = $clog2(N);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q,  out_sel_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            ld;
  logic            sel_ok;
  logic [SELW-1:0] cand;
  logic            cand_ok;
  logic [N-1:0]    in_ready_w;
  logic            xfer;
  logic [W-1:0]    data_sel;

  assign ld     = ~out_valid_q | bus.out_ready;
  assign sel_ok = ({1'b0, bus.sel} < (SELW+1)'(N));

  // Round-robin scan starts at ptr and wraps modulo N, so non-power-of-two N works.
  always_comb begin
    logic found;
    int   idx;
    cand    = '0;
    cand_ok = 1'b0;
    found   = 1'b0;
    idx     = 0;
    if (!bus.mode) begin
      cand    = bus.sel;
      cand_ok = sel_ok;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!found && bus.in_valid[SELW'(idx)]) begin
          found = 1'b1;
          cand  = SELW'(idx);
        end
      end
      cand_ok = found;
    end
  end

  always_comb begin
    in_ready_w = '0;
    data_sel   = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_w[i] = ~rst & ld & cand_ok & (cand == SELW'(i));
      if (cand == SELW'(i)) data_sel = bus.d[i*W +: W];
    end
  end

  assign xfer = |(in_ready_w & bus.in_valid);

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (ld) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = data_sel;
      out_sel_d  = cand;
      if (bus.mode) ptr_d = (cand == SELW'(N-1)) ? '0 : cand + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.sel_err   = ~bus.mode & ~sel_ok;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: table-driven check of muxn_pipe (N=4) plus a hand sequence on N=3.
// Revision: 1.0
`default_nettype none

module tb_muxn_pipe;
  logic clk = 1'b0;
  logic rst4, rst3;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muxn_pipe_if #(.N(4), .W(8)) bus4 ();
  muxn_pipe_if #(.N(3), .W(8)) bus3 ();

  muxn_pipe #(.N(4), .W(8)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
  muxn_pipe #(.N(3), .W(8)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  e_ir;
    logic        e_err;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_os;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] iv,
                     input logic [31:0] d, input logic ordy, input logic [3:0] e_ir,
                     input logic e_err, input logic e_ov, input logic [7:0] e_od,
                     input logic [1:0] e_os);
    vec_t v;
    v.rst = r; v.mode = m; v.sel = s; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_err = e_err; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply4(input vec_t v, input int idx);
    @(negedge clk);
    rst4 = v.rst; bus4.mode = v.mode; bus4.sel = v.sel; bus4.in_valid = v.iv;
    bus4.d = v.d; bus4.out_ready = v.ordy;
    #1;
    chk("in_ready", idx, 32'(bus4.in_ready), 32'(v.e_ir));
    chk("sel_err", idx, 32'(bus4.sel_err), 32'(v.e_err));
    @(posedge clk); #1;
    chk("out_valid", idx, 32'(bus4.out_valid), 32'(v.e_ov));
    chk("out_data", idx, 32'(bus4.out_data), 32'(v.e_od));
    chk("out_sel", idx, 32'(bus4.out_sel), 32'(v.e_os));
  endtask

  task automatic apply3(input int idx, input logic r, input logic m, input logic [1:0] s,
                        input logic [2:0] e_ir, input logic e_err, input logic e_ov,
                        input logic [7:0] e_od, input logic [1:0] e_os);
    @(negedge clk);
    rst3 = r; bus3.mode = m; bus3.sel = s;
    #1;
    chk("n3_in_ready", idx, 32'(bus3.in_ready), 32'(e_ir));
    chk("n3_sel_err", idx, 32'(bus3.sel_err), 32'(e_err));
    @(posedge clk); #1;
    chk("n3_out_valid", idx, 32'(bus3.out_valid), 32'(e_ov));
    chk("n3_out_data", idx, 32'(bus3.out_data), 32'(e_od));
    chk("n3_out_sel", idx, 32'(bus3.out_sel), 32'(e_os));
  endtask

  localparam logic [31:0] DA5 = 32'h00A5_0000;
  localparam logic [31:0] D3C = 32'h003C_0000;
  localparam logic [31:0] DRR = 32'h4433_2211;

  initial begin
    rst4 = 1'b1; rst3 = 1'b1;
    bus4.mode = 1'b0; bus4.sel = '0; bus4.in_valid = '0; bus4.d = '0; bus4.out_ready = 1'b1;
    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = 3'b111; bus3.d = 24'hCC_BB_AA;
    bus3.out_ready = 1'b1;

    //   rst m sel  iv       d    ordy  e_ir    err ov  od     os
    add(1, 0, 0, 4'b1111, 32'h0, 1, 4'b0000, 0, 0, 8'h00, 0);
    add(1, 0, 0, 4'b1111, 32'h0, 1, 4'b0000, 0, 0, 8'h00, 0);
    add(0, 0, 2, 4'b0100, DA5,   1, 4'b0100, 0, 1, 8'hA5, 2);
    add(0, 0, 2, 4'b0100, D3C,   0, 4'b0000, 0, 1, 8'hA5, 2);
    add(0, 0, 2, 4'b0100, D3C,   0, 4'b0000, 0, 1, 8'hA5, 2);
    add(0, 0, 2, 4'b0100, D3C,   0, 4'b0000, 0, 1, 8'hA5, 2);
    add(0, 0, 2, 4'b0100, D3C,   1, 4'b0100, 0, 1, 8'h3C, 2);
    add(0, 0, 2, 4'b0000, D3C,   1, 4'b0100, 0, 0, 8'h3C, 2);
    // Round robin over all channels, then alternating 1,3
    add(0, 1, 0, 4'b1111, DRR,   1, 4'b0001, 0, 1, 8'h11, 0);
    add(0, 1, 0, 4'b1111, DRR,   1, 4'b0010, 0, 1, 8'h22, 1);
    add(0, 1, 0, 4'b1111, DRR,   1, 4'b0100, 0, 1, 8'h33, 2);
    add(0, 1, 0, 4'b1111, DRR,   1, 4'b1000, 0, 1, 8'h44, 3);
    add(0, 1, 0, 4'b1111, DRR,   1, 4'b0001, 0, 1, 8'h11, 0);
    add(0, 1, 0, 4'b1010, DRR,   1, 4'b0010, 0, 1, 8'h22, 1);
    add(0, 1, 0, 4'b1010, DRR,   1, 4'b1000, 0, 1, 8'h44, 3);
    add(0, 1, 0, 4'b1010, DRR,   1, 4'b0010, 0, 1, 8'h22, 1);
    add(0, 1, 0, 4'b1010, DRR,   1, 4'b1000, 0, 1, 8'h44, 3);
    // ptr -> 3, then wrap to channel 0 and ptr -> 1
    add(0, 1, 0, 4'b0100, DRR,   1, 4'b0100, 0, 1, 8'h33, 2);
    add(0, 1, 0, 4'b0001, DRR,   1, 4'b0001, 0, 1, 8'h11, 0);
    add(0, 1, 0, 4'b1111, DRR,   1, 4'b0010, 0, 1, 8'h22, 1);
    // Mid-operation reset with ptr=2
    add(1, 1, 0, 4'b1111, DRR,   1, 4'b0000, 0, 0, 8'h00, 0);
    add(0, 1, 0, 4'b1111, DRR,   1, 4'b0001, 0, 1, 8'h11, 0);
    // Direct mode leaves ptr (=1) alone
    add(0, 0, 3, 4'b1000, DRR,   1, 4'b1000, 0, 1, 8'h44, 3);
    add(0, 1, 0, 4'b1111, DRR,   1, 4'b0010, 0, 1, 8'h22, 1);
    add(0, 1, 0, 4'b1111, DRR,   0, 4'b0000, 0, 1, 8'h22, 1);
    add(0, 1, 0, 4'b1111, DRR,   1, 4'b0100, 0, 1, 8'h33, 2);

    foreach (vq[i]) apply4(vq[i], i);

    // N=3: out-of-range select, then round-robin wrap at N-1
    apply3(100, 1, 0, 2'd0, 3'b000, 0, 0, 8'h00, 0);
    apply3(101, 0, 0, 2'd3, 3'b000, 1, 0, 8'h00, 0);
    apply3(102, 0, 0, 2'd3, 3'b000, 1, 0, 8'h00, 0);
    apply3(103, 0, 0, 2'd2, 3'b100, 0, 1, 8'hCC, 2);
    apply3(104, 0, 1, 2'd0, 3'b001, 0, 1, 8'hAA, 0);
    apply3(105, 0, 1, 2'd0, 3'b010, 0, 1, 8'hBB, 1);
    apply3(106, 0, 1, 2'd0, 3'b100, 0, 1, 8'hCC, 2);
    apply3(107, 0, 1, 2'd0, 3'b001, 0, 1, 8'hAA, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
